// File: rtl/pcap_ring_sched.sv
// pcap_ring_sched: allocates host-ring slots for capture records and
// sequences one write-controller command per admitted descriptor.
module pcap_ring_sched #(
  parameter int DESC_DEPTH     = 8,
  parameter int MAX_LEN        = 2048,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ring_base,
  input  logic [31:0] ring_size,
  input  logic [31:0] sw_rd_ptr,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_begin,
  input  logic [31:0] desc_end,
  output logic        wr_ctrl,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] hw_wr_ptr,
  output logic [31:0] rec_count,
  output logic [31:0] drop_count,
  output logic        timeout_err,
  output logic        busy
);

  localparam int AW = $clog2(DESC_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t r_state;

  logic [31:0] r_fb [DESC_DEPTH];
  logic [31:0] r_fe [DESC_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;

  logic [31:0] r_hbeg;
  logic [31:0] r_hend;
  logic [31:0] r_off;
  logic [33:0] r_rec;
  logic [TW-1:0] r_wcnt;
  logic [15:0] r_seq;

  logic        r_wr_ctrl;
  logic [31:0] r_ctrl;
  logic [31:0] r_pbeg;
  logic [31:0] r_pend;
  logic [31:0] r_addr;
  logic [31:0] r_hw;
  logic [31:0] r_rcnt;
  logic [31:0] r_dcnt;
  logic        r_tout;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  logic [31:0] w_len;
  logic [33:0] w_pad;
  logic [33:0] w_rec;
  logic [33:0] w_hw;
  logic [33:0] w_sw;
  logic [33:0] w_size;
  logic [33:0] w_free;
  logic [33:0] w_need;
  logic        w_fit;
  logic        w_over;
  logic        w_drop;
  logic [31:0] w_off;
  logic [33:0] w_end;
  logic [31:0] w_next;

  // A full FIFO still accepts a push in the cycle the FSM pops it.
  assign w_empty = (r_cnt == '0);
  assign w_pop   = (r_state == S_IDLE) && !w_empty && enable;
  assign w_full  = (r_cnt == (AW+1)'(DESC_DEPTH)) && !w_pop;
  assign desc_ready = reset && enable && !w_full;
  assign w_push  = desc_valid && desc_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fb[r_wp] <= desc_begin;
      r_fe[r_wp] <= desc_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Slot allocation, evaluated against the held descriptor in CHECK.
  assign w_len  = r_hend - r_hbeg;
  assign w_pad  = ({2'b00, w_len} + 34'd15) & ~34'd15;
  assign w_rec  = w_pad + 34'd16;
  assign w_hw   = {2'b00, r_hw};
  assign w_sw   = {2'b00, sw_rd_ptr};
  assign w_size = {2'b00, ring_size};

  always_comb begin
    w_free = '0;
    if (w_hw >= w_sw)
      w_free = w_size - (w_hw - w_sw);
    else
      w_free = w_sw - w_hw;
  end

  assign w_fit  = (w_hw + w_rec) <= w_size;
  assign w_need = w_fit ? w_rec : (w_size - w_hw + w_rec);
  assign w_over = w_len > 32'(MAX_LEN);
  assign w_drop = w_over || (w_need >= w_free);
  assign w_off  = w_fit ? r_hw : 32'd0;

  assign w_end  = {2'b00, r_off} + r_rec;
  assign w_next = (w_end == w_size) ? 32'd0 : w_end[31:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_hbeg    <= '0;
      r_hend    <= '0;
      r_off     <= '0;
      r_rec     <= '0;
      r_wcnt    <= '0;
      r_seq     <= '0;
      r_wr_ctrl <= 1'b0;
      r_ctrl    <= '0;
      r_pbeg    <= '0;
      r_pend    <= '0;
      r_addr    <= '0;
      r_hw      <= '0;
      r_rcnt    <= '0;
      r_dcnt    <= '0;
      r_tout    <= 1'b0;
    end else begin
      r_wr_ctrl <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_hbeg  <= r_fb[r_rp];
            r_hend  <= r_fe[r_rp];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_drop) begin
            r_dcnt  <= r_dcnt + 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_off     <= w_off;
            r_rec     <= w_rec;
            r_addr    <= ring_base + w_off;
            r_ctrl    <= {r_seq, 14'd0, ~w_fit, 1'b1};
            r_pbeg    <= r_hbeg;
            r_pend    <= r_hend;
            r_wr_ctrl <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (wr_ctrl_rdy) begin
            r_state <= S_COMMIT;
          end else if (r_wcnt == TMAX) begin
            r_tout  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_COMMIT: begin
          r_hw    <= w_next;
          r_rcnt  <= r_rcnt + 1'b1;
          r_seq   <= r_seq + 1'b1;
          r_state <= S_IDLE;
        end
        S_HALT: begin
          if (!enable)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_ctrl       = r_wr_ctrl;
  assign control       = r_ctrl;
  assign pkt_begin     = r_pbeg;
  assign pkt_end       = r_pend;
  assign write_address = r_addr;
  assign hw_wr_ptr     = r_hw;
  assign rec_count     = r_rcnt;
  assign drop_count    = r_dcnt;
  assign timeout_err   = r_tout;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pcap_ring_sched.sv
// tb_pcap_ring_sched: directed and randomized checks of pcap_ring_sched
// against a queue-based ring allocation model.
module tb_pcap_ring_sched;

  localparam int DD = 8;
  localparam int ML = 2048;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] ring_base;
  logic [31:0] ring_size;
  logic [31:0] sw_rd_ptr;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_begin;
  logic [31:0] desc_end;
  logic        wr_ctrl;
  logic [31:0] control;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] write_address;
  logic        wr_ctrl_rdy;
  logic [31:0] hw_wr_ptr;
  logic [31:0] rec_count;
  logic [31:0] drop_count;
  logic        timeout_err;
  logic        busy;

  logic r_rdy;
  logic spur;
  assign wr_ctrl_rdy = r_rdy | spur;

  pcap_ring_sched #(
    .DESC_DEPTH(DD),
    .MAX_LEN(ML),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ring_base(ring_base),
    .ring_size(ring_size),
    .sw_rd_ptr(sw_rd_ptr),
    .desc_valid(desc_valid),
    .desc_ready(desc_ready),
    .desc_begin(desc_begin),
    .desc_end(desc_end),
    .wr_ctrl(wr_ctrl),
    .control(control),
    .pkt_begin(pkt_begin),
    .pkt_end(pkt_end),
    .write_address(write_address),
    .wr_ctrl_rdy(wr_ctrl_rdy),
    .hw_wr_ptr(hw_wr_ptr),
    .rec_count(rec_count),
    .drop_count(drop_count),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
  } desc_t;

  desc_t       m_q[$];
  longint      m_hw;
  int unsigned m_rec;
  int unsigned m_drop;
  int unsigned m_seq;
  bit          withhold;
  int          rdy_lo;
  int          rdy_hi;
  int          n_pulse;
  bit          stalled;
  logic [31:0] last_addr;
  logic [31:0] last_ctrl;

  // Ring allocation rules in plain integer arithmetic.
  function automatic bit m_eval(input desc_t d, output longint off,
                                output longint rec, output bit wrap);
    logic [31:0] l32;
    longint len, sz, sw, free, need;
    l32  = d.e - d.b;
    len  = longint'({32'd0, l32});
    sz   = longint'({32'd0, ring_size});
    sw   = longint'({32'd0, sw_rd_ptr});
    rec  = 16 + ((len + 15) / 16) * 16;
    free = (m_hw >= sw) ? sz - (m_hw - sw) : sw - m_hw;
    wrap = (m_hw + rec > sz);
    off  = wrap ? 0 : m_hw;
    need = wrap ? (sz - m_hw + rec) : rec;
    if (len > ML) return 1'b0;
    return need < free;
  endfunction

  task automatic handle();
    desc_t  d;
    longint off, rec;
    bit     wrap, ok;
    int     dly;
    logic [31:0] exp_addr;
    ok = 1'b0;
    off = 0;
    rec = 0;
    wrap = 1'b0;
    n_pulse++;
    last_addr = write_address;
    last_ctrl = control;
    while (m_q.size() > 0 && !ok) begin
      d = m_q.pop_front();
      ok = m_eval(d, off, rec, wrap);
      if (!ok) m_drop++;
    end
    chk("cmd_expected", {31'd0, ok}, 32'd1);
    exp_addr = ring_base + off[31:0];
    if (ok) begin
      chk("addr", write_address, exp_addr);
      chk("ctrl", control, {m_seq[15:0], 14'd0, wrap, 1'b1});
      chk("pbeg", pkt_begin, d.b);
      chk("pend", pkt_end, d.e);
    end
    if (!withhold) begin
      dly = rdy_lo + int'($urandom_range(rdy_hi - rdy_lo));
      @(negedge clk);
      chk("pulse_len", {31'd0, wr_ctrl}, 32'd0);
      repeat (dly) @(negedge clk);
      if (ok) chk("hold_addr", write_address, exp_addr);
      r_rdy = 1'b1;
      @(negedge clk);
      r_rdy = 1'b0;
      if (ok) begin
        m_hw = off + rec;
        if (m_hw == longint'({32'd0, ring_size})) m_hw = 0;
        m_rec++;
        m_seq++;
      end
    end
  endtask

  initial begin
    r_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && wr_ctrl) handle();
    end
  end

  task automatic push(logic [31:0] b, logic [31:0] l);
    int t;
    desc_t d;
    t = 0;
    desc_begin = b;
    desc_end   = b + l;
    desc_valid = 1'b1;
    while (!desc_ready && t < 3000) begin
      stalled = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    d.b = b;
    d.e = b + l;
    m_q.push_back(d);
  endtask

  task automatic drain();
    int t, q;
    desc_t d;
    longint off, rec;
    bit wrap, ok;
    t = 0;
    q = 0;
    while (q < 4 && t < 5000) begin
      @(negedge clk);
      t++;
      q = busy ? 0 : q + 1;
    end
    if (t >= 5000) chk("drain_timeout", 32'd0, 32'd1);
    while (m_q.size() > 0) begin
      d = m_q.pop_front();
      ok = m_eval(d, off, rec, wrap);
      chk("missing_cmd", {31'd0, ok}, 32'd0);
      m_drop++;
    end
    chk("hw_ptr", hw_wr_ptr, m_hw[31:0]);
    chk("rec_count", rec_count, m_rec);
    chk("drop_count", drop_count, m_drop);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    desc_valid = 1'b0;
    repeat (3) @(negedge clk);
    m_q.delete();
    m_hw = 0;
    m_rec = 0;
    m_drop = 0;
    m_seq = 0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pulse();
    int t;
    t = 0;
    while (!wr_ctrl && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, t;
    reset = 1'b0;
    enable = 1'b1;
    ring_base = 32'h8000_0000;
    ring_size = 32'h1000;
    sw_rd_ptr = 32'h0;
    desc_valid = 1'b0;
    desc_begin = '0;
    desc_end = '0;
    spur = 1'b0;
    withhold = 1'b0;
    rdy_lo = 1;
    rdy_hi = 3;
    n_pulse = 0;
    stalled = 1'b0;
    m_hw = 0;
    m_rec = 0;
    m_drop = 0;
    m_seq = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    chk("rst_control", control, 32'd0);
    chk("rst_addr", write_address, 32'd0);
    chk("rst_pbeg", pkt_begin, 32'd0);
    chk("rst_hw", hw_wr_ptr, 32'd0);
    chk("rst_rec", rec_count, 32'd0);
    chk("rst_drop", drop_count, 32'd0);
    chk("rst_tout", {31'd0, timeout_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, desc_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    push(32'h200, 32'h64);
    drain();
    chk("t1_addr", last_addr, 32'h8000_0000);
    chk("t1_ctrl", last_ctrl, 32'h0000_0001);
    chk("t1_hw", hw_wr_ptr, 32'h80);
    chk("t1_rec", rec_count, 32'd1);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_rec", rec_count, 32'd1);

    sw_rd_ptr = 32'h100;
    np = n_pulse;
    push(32'h1000, 32'd100);
    drain();
    chk("full_no_cmd", n_pulse, np);
    chk("full_drop", drop_count, 32'd1);
    chk("full_ready", {31'd0, desc_ready}, 32'd1);

    sw_rd_ptr = 32'h80;
    push(32'h0, 32'd3000);
    drain();
    chk("over_drop", drop_count, 32'd2);
    chk("over_hw", hw_wr_ptr, 32'h80);

    do_reset();
    sw_rd_ptr = 32'h0;
    push(32'h0, 32'd2032);
    push(32'h0, 32'd1968);
    drain();
    chk("pre_wrap_hw", hw_wr_ptr, 32'hFC0);
    sw_rd_ptr = 32'h100;
    push(32'h40, 32'd64);
    drain();
    chk("wrap_addr", last_addr, 32'h8000_0000);
    chk("wrap_bit", {31'd0, last_ctrl[1]}, 32'd1);
    chk("wrap_hw", hw_wr_ptr, 32'h50);

    withhold = 1'b1;
    np = n_pulse;
    push(32'h300, 32'd40);
    wait_pulse();
    t = 0;
    while (!timeout_err && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("to_cycles", t, 32'd17);
    push(32'h400, 32'd40);
    repeat (20) @(negedge clk);
    chk("halt_no_pop", n_pulse, np + 1);
    chk("halt_busy", {31'd0, busy}, 32'd1);
    withhold = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_exit", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    drain();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("after_halt_cmd", n_pulse, np + 2);

    withhold = 1'b1;
    push(32'h500, 32'd16);
    wait_pulse();
    repeat (3) @(negedge clk);
    do_reset();
    withhold = 1'b0;
    chk("rw_hw", hw_wr_ptr, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_tout", {31'd0, timeout_err}, 32'd0);
    chk("rw_rec", rec_count, 32'd0);

    sw_rd_ptr = 32'h0;
    rdy_lo = 8;
    rdy_hi = 8;
    stalled = 1'b0;
    for (int i = 0; i < 10; i++)
      push(32'(i) * 32'h100, 32'(16 * i + 8));
    chk("burst_stall", {31'd0, stalled}, 32'd1);
    drain();
    chk("burst_rec", rec_count, 32'd10);

    do_reset();
    ring_size = 32'h400;
    ring_base = $urandom() & 32'hFFFF_FFF0;
    rdy_lo = 1;
    rdy_hi = 5;
    for (int bt = 0; bt < 8; bt++) begin
      sw_rd_ptr = 32'($urandom_range(63)) * 32'd16;
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(99) < 8)
          push($urandom(), 32'($urandom_range(3000, 2049)));
        else
          push($urandom(), 32'($urandom_range(400)));
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
